uart_tx_arbiter: RTL

//   Shares the single UART transmitter between N_REQ byte producers.
//   - Round-robin grant, one byte per grant.
//   - Drives tx_start/tx_data into the uart wrapper and holds tx_start until the transmitter reports busy.
//   - Enforces an idle gap between frames.
//   - Sits between the application byte sources (display echo, status reporter, ...) and uart.

---
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: groups the byte-producer handshake and the transmitter
// handshake of the UART transmit arbiter.
//
// Handshakes:
//   req_valid[i]/req_ready[i]: requester i raises req_valid with its byte on
//     req_data[8*i+7:8*i] and holds both until the single-cycle req_ready[i]
//     pulse, which marks the byte as captured. Dropping valid early is legal.
//   tx_start/tx_busy: tx_start is a held level with tx_data stable. It falls
//     once the transmitter reports tx_busy.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int GID_W = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic               busy;
    logic [GID_W-1:0]   grant_id;
    logic               timeout_err;

    // Arbiter side.
    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data, busy, grant_id, timeout_err
    );

    // Environment side: requesters plus transmitter.
    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between N_REQ
// byte producers, one byte per grant, with an enforced idle gap after each
// frame.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN. When it is defined, a frame
// stuck in START/WAIT for TIMEOUT_CYCLES is aborted and its byte dropped.
// dbg_state exposes the FSM state (0 IDLE, 1 START, 2 WAIT, 3 GAP).
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arbiter_if.master  bus,
    output logic [1:0]         dbg_state
);
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, GAP = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               timeout_err_d;

    logic               hit;
    logic [GID_W-1:0]   hit_idx;
    logic [7:0]         hit_byte;
    int                 idx;

    // Rotating search: first valid requester after the last one served.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_byte = '0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!hit && bus.req_valid[idx]) begin
                hit      = 1'b1;
                hit_idx  = GID_W'(idx);
                hit_byte = bus.req_data[8*idx +: 8];
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q;
`endif

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = tx_start_q;
        req_ready_d   = '0;
        gap_d         = gap_q;
        timeout_err_d = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (hit) begin
                    tx_data_d            = hit_byte;
                    grant_id_d           = hit_idx;
                    rr_ptr_d             = hit_idx;
                    req_ready_d[hit_idx] = 1'b1;
                    tx_start_d           = 1'b1;
                    state_d              = START;
                end
            end
            START: begin
                // Busy already high on entry counts as the handshake.
                if (bus.tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (!bus.tx_busy) begin
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
        // Abort overrides the normal START/WAIT progress; the byte is lost.
        if (state_q == IDLE) begin
            to_cnt_d = '0;
        end else if (state_q == START || state_q == WAIT) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                tx_start_d    = 1'b0;
                timeout_err_d = 1'b1;
                gap_d         = GAP_W'(GAP_CYCLES - 1);
                state_d       = GAP;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= GID_W'(N_REQ - 1);
            grant_id_q  <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            req_ready_q <= req_ready_d;
            gap_q       <= gap_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Timeout counter and abort pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout  = timeout_err_d;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q != IDLE);
    assign dbg_state     = state_q;
endmodule
